// File: rtl/ex_redirect_ctrl_pkg.sv
// Shared constants and state encoding for the exception/ERET redirect controller.
package ex_redirect_ctrl_pkg;

  localparam logic [31:0] EX_ENTRY_PC = 32'hbfc00380;
  localparam int          ERC_CNT_W   = 16;

  typedef enum logic [1:0] {
    ERC_IDLE     = 2'd0,
    ERC_FLUSH    = 2'd1,
    ERC_REDIRECT = 2'd2
  } erc_state_t;

endpackage

// File: rtl/ex_redirect_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous active-low clear.
// Count is visible the cycle after inc; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ex_redirect_ctrl.sv
// Kills younger stages on WS exception/ERET, flushes FLUSH_CYCLES cycles, then offers one redirect PC.
// flush_o is combinational in the event cycle; the redirect holds indefinitely until redirect_ready_i.
module ex_redirect_ctrl
  import ex_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY     = EX_ENTRY_PC,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int          CNT_W        = ERC_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ws_ex_i,
  input  logic             ws_eret_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             redirect_ready_i,
  output logic             flush_o,
  output logic             busy_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] ex_cnt_o
);

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  erc_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic        evt;
  logic        ex_inc;

  assign evt = ws_ex_i | ws_eret_i;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ERC_IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    target_d         = target_q;
    flush_o          = 1'b0;
    busy_o           = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    ex_inc           = 1'b0;
    case (state_q)
      ERC_IDLE: begin
        // Same-cycle kill so younger stages clear on the edge WS retires.
        flush_o = evt;
        if (evt) begin
          target_d = ws_ex_i ? EX_ENTRY : cp0_epc_i;
          cnt_d    = FLUSH_LD;
          state_d  = ERC_FLUSH;
          ex_inc   = ws_ex_i;
        end
      end
      ERC_FLUSH: begin
        flush_o = 1'b1;
        busy_o  = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ERC_REDIRECT;
        end
      end
      ERC_REDIRECT: begin
        busy_o           = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) begin
          state_d = ERC_IDLE;
        end
      end
      default: begin
        state_d = ERC_IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_ex_cnt (
    .clk   (clk),
    .clr_n (resetn),
    .inc   (ex_inc),
    .cnt   (ex_cnt_o)
  );

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Directed bench: dut1 uses default parameters, dut2 uses CNT_W=4 and FLUSH_CYCLES=3 on shared inputs.
module tb_ex_redirect_ctrl;

  logic        clk;
  logic        resetn;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] epc;
  logic        ready;

  logic        f1, b1, v1;
  logic [31:0] pc1;
  logic [15:0] c1;
  logic        f2, b2, v2;
  logic [31:0] pc2;
  logic [3:0]  c2;

  int checks = 0;
  int errors = 0;

  ex_redirect_ctrl dut1 (
    .clk              (clk),
    .resetn           (resetn),
    .ws_ex_i          (ws_ex),
    .ws_eret_i        (ws_eret),
    .cp0_epc_i        (epc),
    .redirect_ready_i (ready),
    .flush_o          (f1),
    .busy_o           (b1),
    .redirect_valid_o (v1),
    .redirect_pc_o    (pc1),
    .ex_cnt_o         (c1)
  );

  ex_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut2 (
    .clk              (clk),
    .resetn           (resetn),
    .ws_ex_i          (ws_ex),
    .ws_eret_i        (ws_eret),
    .cp0_epc_i        (epc),
    .redirect_ready_i (ready),
    .flush_o          (f2),
    .busy_o           (b2),
    .redirect_valid_o (v2),
    .redirect_pc_o    (pc2),
    .ex_cnt_o         (c2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Lets dut2 (longer flush) finish any pending redirect.
  task automatic drain;
    ready = 1'b1;
    repeat (6) tick();
    ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0; epc = 32'd0; ready = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", f1); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", b1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v1); end
    checks++; if (pc1 !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc1); end
    checks++; if (c1 !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", c1); end
    checks++; if (c2 !== 4'd0) begin errors++; $display("FAIL reset_cnt2 got %h exp 0", c2); end
  endtask

  task automatic test_exception;
    ws_ex = 1'b1;
    #1;
    checks++; if (f1 !== 1'b1) begin errors++; $display("FAIL ex_evt_flush got %b exp 1", f1); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL ex_evt_busy got %b exp 0", b1); end
    tick();
    ws_ex = 1'b0;
    #1;
    checks++; if ({f1, b1, v1} !== 3'b110) begin errors++; $display("FAIL ex_flush_state got %b exp 110", {f1, b1, v1}); end
    tick();
    #1;
    checks++; if ({f1, b1, v1} !== 3'b011) begin errors++; $display("FAIL ex_redir_state got %b exp 011", {f1, b1, v1}); end
    checks++; if (pc1 !== 32'hbfc00380) begin errors++; $display("FAIL ex_redir_pc got %h exp bfc00380", pc1); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    checks++; if ({f1, b1, v1} !== 3'b000) begin errors++; $display("FAIL ex_idle_state got %b exp 000", {f1, b1, v1}); end
    checks++; if (pc1 !== 32'd0) begin errors++; $display("FAIL ex_idle_pc got %h exp 0", pc1); end
    checks++; if (c1 !== 16'd1) begin errors++; $display("FAIL ex_cnt got %0d exp 1", c1); end
    drain();
  endtask

  task automatic test_eret_delayed_ready;
    ws_eret = 1'b1; epc = 32'hbfc00104;
    #1;
    checks++; if (f1 !== 1'b1) begin errors++; $display("FAIL eret_evt_flush got %b exp 1", f1); end
    tick();
    ws_eret = 1'b0; epc = 32'h0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (v1 !== 1'b1 || pc1 !== 32'hbfc00104 || f1 !== 1'b0) begin
        errors++; $display("FAIL eret_hold cycle %0d got v=%b pc=%h f=%b exp v=1 pc=bfc00104 f=0", i, v1, pc1, f1);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    checks++; if (b1 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL eret_accept got b=%b v=%b exp 0 0", b1, v1); end
    checks++; if (c1 !== 16'd1) begin errors++; $display("FAIL eret_cnt got %0d exp 1", c1); end
    drain();
  endtask

  task automatic test_simultaneous;
    ws_ex = 1'b1; ws_eret = 1'b1; epc = 32'h1234;
    tick();
    ws_ex = 1'b0; ws_eret = 1'b0; epc = 32'h0;
    tick();
    #1;
    checks++; if (pc1 !== 32'hbfc00380) begin errors++; $display("FAIL simul_pc got %h exp bfc00380", pc1); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    checks++; if (c1 !== 16'd2) begin errors++; $display("FAIL simul_cnt got %0d exp 2", c1); end
    drain();
    checks++; if (c2 !== 4'd2) begin errors++; $display("FAIL simul_cnt2 got %0d exp 2", c2); end
  endtask

  task automatic test_busy_events;
    ws_ex = 1'b1;
    tick();
    #1;
    checks++; if (b1 !== 1'b1 || f1 !== 1'b1) begin errors++; $display("FAIL busy_in_flush got b=%b f=%b exp 1 1", b1, f1); end
    tick();
    ws_ex = 1'b0; ws_eret = 1'b1; epc = 32'hdead0000;
    #1;
    checks++; if (f1 !== 1'b0) begin errors++; $display("FAIL busy_redir_flush got %b exp 0", f1); end
    checks++; if (pc1 !== 32'hbfc00380) begin errors++; $display("FAIL busy_redir_pc got %h exp bfc00380", pc1); end
    tick();
    ws_eret = 1'b0; epc = 32'h0;
    #1;
    checks++; if (v1 !== 1'b1 || pc1 !== 32'hbfc00380) begin errors++; $display("FAIL busy_retarget got v=%b pc=%h exp 1 bfc00380", v1, pc1); end
    checks++; if (c1 !== 16'd3) begin errors++; $display("FAIL busy_cnt got %0d exp 3", c1); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    checks++; if (v1 !== 1'b0 || c1 !== 16'd3) begin errors++; $display("FAIL busy_after got v=%b cnt=%0d exp 0 3", v1, c1); end
    drain();
    checks++; if (c2 !== 4'd3) begin errors++; $display("FAIL busy_cnt2 got %0d exp 3", c2); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 17; i++) begin
      ws_ex = 1'b1;
      tick();
      ws_ex = 1'b0;
      drain();
      if (i == 11) begin
        checks++; if (c2 !== 4'hf) begin errors++; $display("FAIL sat_reach got %h exp f", c2); end
      end
    end
    #1;
    checks++; if (c2 !== 4'hf) begin errors++; $display("FAIL sat_hold got %h exp f", c2); end
    checks++; if (c1 !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt got %0d exp 20", c1); end
  endtask

  task automatic test_reset_mid_redirect;
    ws_ex = 1'b1;
    tick();
    ws_ex = 1'b0;
    tick();
    #1;
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", v1); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++; if ({f1, b1, v1} !== 3'b000) begin errors++; $display("FAIL rst_mid_state got %b exp 000", {f1, b1, v1}); end
    checks++; if (pc1 !== 32'd0 || c1 !== 16'd0) begin errors++; $display("FAIL rst_mid_regs got pc=%h cnt=%0d exp 0 0", pc1, c1); end
    checks++; if (b2 !== 1'b0 || c2 !== 4'd0) begin errors++; $display("FAIL rst_mid_dut2 got b=%b cnt=%0d exp 0 0", b2, c2); end
    ws_eret = 1'b1; epc = 32'h80;
    tick();
    ws_eret = 1'b0; epc = 32'h0;
    tick();
    #1;
    checks++; if (v1 !== 1'b1 || pc1 !== 32'h80) begin errors++; $display("FAIL rst_eret_pc got v=%b pc=%h exp 1 80", v1, pc1); end
    drain();
  endtask

  task automatic test_flush3;
    int flush_cycles;
    int valid_at;
    flush_cycles = 0;
    valid_at = -1;
    ws_eret = 1'b1; epc = 32'h44;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (f2 === 1'b1) flush_cycles++;
      if (v2 === 1'b1 && valid_at < 0) begin
        valid_at = i;
        checks++; if (pc2 !== 32'h44) begin errors++; $display("FAIL f3_pc got %h exp 44", pc2); end
      end
      tick();
      ws_eret = 1'b0; epc = 32'h0;
    end
    checks++; if (flush_cycles != 4) begin errors++; $display("FAIL f3_flush_len got %0d exp 4", flush_cycles); end
    checks++; if (valid_at != 4) begin errors++; $display("FAIL f3_valid_at got %0d exp 4", valid_at); end
    #1;
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL f3_hold got %b exp 1", v2); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    // Back-to-back event immediately after the handshake is accepted.
    ws_ex = 1'b1;
    #1;
    checks++; if (f2 !== 1'b1 || b2 !== 1'b0) begin errors++; $display("FAIL b2b_evt got f=%b b=%b exp 1 0", f2, b2); end
    tick();
    ws_ex = 1'b0;
    #1;
    checks++; if (b2 !== 1'b1 || c2 !== 4'd1) begin errors++; $display("FAIL b2b_accept got b=%b cnt=%0d exp 1 1", b2, c2); end
    drain();
  endtask

  initial begin
    test_reset();
    test_exception();
    test_eret_delayed_ready();
    test_simultaneous();
    test_busy_events();
    test_saturation();
    test_reset_mid_redirect();
    test_flush3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_redirect_ctrl.md
Name: ex_redirect_ctrl

Overview:
- Sequences the pipeline response to a writeback-stage exception or ERET.
- Kills all younger instructions, holds the flush for a programmable number of cycles, then presents one redirect PC to the pre-IF stage with a valid/ready handshake.
- Sits between wb_stage (WS_EX, ERET, cp0_epc) and the IF/ID/EXE/MEM stage valid registers and the pre-IF next-PC mux.

Parameters:
- EX_ENTRY, 32'hbfc00380, exception vector used as the redirect target for any exception.
- FLUSH_CYCLES, 1, number of cycles flush_o stays asserted in state FLUSH; legal range 1..15.
- CNT_W, 16, width of the saturating exception counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous active-low reset.
- ws_ex_i  input  1  writeback stage raises an exception this cycle (WS_EX).
- ws_eret_i  input  1  writeback stage retires ERET this cycle.
- cp0_epc_i  input  32  EPC value, valid in the same cycle as ws_eret_i.
- redirect_ready_i  input  1  pre-IF accepts the redirect PC this cycle.
- flush_o  output  1  clear valid in IF/ID/EXE/MEM.
- busy_o  output  1  controller not idle; ID must not issue.
- redirect_valid_o  output  1  redirect PC offered to pre-IF.
- redirect_pc_o  output  32  redirect target.
- ex_cnt_o  output  CNT_W  number of accepted exceptions, saturating.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state goes to IDLE; target register, flush counter and ex_cnt_o go to 0.
  - All outputs are 0 in the cycle after reset. Reset overrides any event in the same cycle.
  - Reset mid-FLUSH or mid-REDIRECT abandons the redirect; no pending target survives.
- States: IDLE, FLUSH, REDIRECT. Encoding constants live in mycpu.h.
- IDLE, event detection:
  - event = ws_ex_i | ws_eret_i.
  - flush_o = event combinationally, so younger stages are killed at the same edge as WS.
  - On event:
    - Latch target = EX_ENTRY if ws_ex_i, else cp0_epc_i. ws_ex_i has priority when both are high, and the ERET is dropped.
    - Load the flush counter with FLUSH_CYCLES and go to FLUSH.
    - ex_cnt_o increments only when ws_ex_i=1. It saturates at all-ones and does not wrap.
  - busy_o=0 and redirect_valid_o=0 in IDLE.
- FLUSH:
  - flush_o=1, busy_o=1, redirect_valid_o=0.
  - The counter decrements each cycle. When counter==1, go to REDIRECT.
  - Total flush_o high time after the event cycle is exactly FLUSH_CYCLES cycles.
- REDIRECT:
  - flush_o=0, busy_o=1, redirect_valid_o=1, redirect_pc_o=target. These hold stable until handshake.
  - On redirect_ready_i=1, go to IDLE next cycle. Redirect latency is 0 beyond ready.
  - redirect_ready_i=0 holds the state indefinitely with no timeout.
- Event inputs in FLUSH or REDIRECT are ignored: no retarget and no count. The bench checks this.
- redirect_pc_o is 0 whenever not in REDIRECT.
- A back-to-back event in the IDLE cycle immediately following a handshake is accepted normally. The minimum spacing between two redirects is FLUSH_CYCLES+2 cycles.
- ready arriving in FLUSH has no effect.
- Arithmetic:
  - The flush counter is 4 bits and unsigned.
  - The ex_cnt_o increment is guarded: if (ex_cnt_o != all-ones).

Decomposition:
- mycpu.h gains:
  - `EX_ENTRY_PC 32'hbfc00380`
  - `ERC_IDLE 2'd0`, `ERC_FLUSH 2'd1`, `ERC_REDIRECT 2'd2`
  - `ERC_CNT_W`
- One sub-module, sat_counter (width-parameterised increment with saturate and synchronous active-low clear), instantiated for ex_cnt_o.
- The FSM and target register stay in ex_redirect_ctrl.

Test Plan:
- Exception path: reset 3 cycles, then ws_ex_i=1 for 1 cycle with FLUSH_CYCLES=1.
  - flush_o high in the event cycle and 1 following cycle.
  - Next cycle redirect_valid_o=1, redirect_pc_o=32'hbfc00380.
  - redirect_ready_i=1 gives IDLE next cycle; ex_cnt_o=1.
- ERET with delayed ready: ws_eret_i=1, cp0_epc_i=32'h bfc00104, redirect_ready_i low for 5 cycles.
  - redirect_pc_o=32'hbfc00104 stable for all 5 REDIRECT cycles, then accepted.
  - ex_cnt_o unchanged.
- Simultaneous events: ws_ex_i=1 and ws_eret_i=1 with cp0_epc_i=32'h1234.
  - Target is 32'hbfc00380 and ex_cnt_o increments by 1.
- Events while busy: ws_ex_i pulse in FLUSH, ws_eret_i pulse in REDIRECT with epc=32'hdead0000.
  - Target unchanged; ex_cnt_o increments only once.
- Saturation with CNT_W=4: 17 separate exceptions end with ex_cnt_o=4'hf.
- Reset mid-REDIRECT: resetn=0 one cycle while redirect_valid_o=1.
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent ERET with epc=32'h80 redirects to 32'h80.
  - FLUSH_CYCLES=3 variant: flush_o high for exactly 4 cycles in total (event cycle plus 3).
